exec_top: RTL and testbench
===========================

# exec_top

Execute stage of the team's 32-bit RISC-V-style pipeline. The block takes decoded operands and an ALU control code, computes the ALU result, and resolves branches and jumps. It registers all results for the memory/writeback stage and returns a redirect flag and target PC to fetch.

## Interface
Parameters: none (width fixed at 32).
- clk  in  1  pipeline clock; all state updates on the rising edge
- rstn  in  1  reset, asynchronous, active-high (asserted = 1 despite the name)
- ALU_Control  in  6  operation code, encodings under Operation
- branch_op  in  1  qualifies redirects; no redirect unless 1
- operand_A  in  32  first ALU operand (rs1 or PC, per decode)
- operand_B  in  32  second ALU operand (rs2 or immediate, per decode)
- Rdata1  in  32  raw rs1 value, base address for JALR
- imm32  in  32  sign-extended immediate, branch/jump offset
- PC  in  32  PC of the instruction in execute
- ALU_result  out  32  registered result
- jump_flag  out  1  registered redirect request
- jump_target_PC  out  32  registered redirect target

## Operation
Shifts use B[4:0]; signed ops treat values as two's complement; all arithmetic wraps modulo 2^32.
- 0x00 ADD: A+B
- 0x01 SUB: A−B
- 0x02 AND: A&B
- 0x03 OR: A|B
- 0x04 XOR: A^B
- 0x05 SLL: A<<B[4:0]
- 0x06 SRL: logical right shift
- 0x07 SRA: arithmetic right shift
- 0x08 SLT: result 1 if A<B signed, else 0
- 0x09 SLTU: result 1 if A<B unsigned, else 0
- 0x0A PASSB: B (LUI)
- 0x0B AUIPC: PC+imm32
- 0x10–0x15 BEQ/BNE/BLT/BGE/BLTU/BGEU:
  - condition compares A against B (signed for BLT/BGE, unsigned for BLTU/BGEU)
  - result 0; target PC+imm32
- 0x18 JAL: result PC+4; target PC+imm32; condition true
- 0x19 JALR: result PC+4; target (Rdata1+imm32) with bit 0 cleared; condition true
- Any other code: result 0, condition false, target 0.
- jump_flag = branch_op AND condition. For non-branch/jump codes, jump_flag is 0 regardless of branch_op.
- jump_target_PC is computed for every branch/jump code even when jump_flag is 0.

## Timing
- All three outputs are registered, with 1-cycle latency: inputs sampled at rising edge N appear on outputs after edge N, stable until edge N+1.
- Reset asynchronously forces ALU_result=0, jump_flag=0, jump_target_PC=0, immediately, not waiting for clk.
- Outputs hold 0 while reset is asserted. The first edge after deassertion loads computed values.
- No handshake: a new operation is accepted every cycle.
- Reset asserted mid-stream discards the in-flight result; no partial state persists.
- The block does not flush or stall. Consumers must ignore the result in the cycle after jump_flag=1.

## Structure
- Package exec_pkg: ALU op-code localparams/enum (6-bit), XLEN=32 constant.
- Sub-module exec_alu: purely combinational. Inputs: op, A, B, PC, imm32, Rdata1. Outputs: result, condition, target.
- exec_top: instantiates exec_alu, applies branch_op gating, and holds the output registers with async reset.

## Test plan
- Reset: hold rstn=1 → all outputs 0. Deassert, then ADD with A=1, B=2 → ALU_result=3 one edge later, jump_flag=0.
- Logic/shift: AND A=1, B=10 → 0. SRA A=0x80000000, B=4 → 0xF8000000. SUB A=0, B=1 → 0xFFFFFFFF.
- Compare: SLT A=0xFFFFFFFF, B=1 → 1. SLTU with the same operands → 0.
- Branch: BEQ with A=B=5, PC=0x100, imm32=0x20.
  - branch_op=1 → jump_flag=1, target 0x120.
  - branch_op=0 → jump_flag=0, target still 0x120.
- Jumps: JALR with Rdata1=0x1001, imm32=4, PC=0x40, branch_op=1 → target 0x1004, result 0x44. JAL with PC=0x40, imm32=−8 → target 0x38.
- Async reset: assert rstn between clock edges during a BEQ-taken cycle → jump_flag drops to 0 immediately.

Source files
------------

// File: rtl/exec_pkg.sv
//------------------------------------------------------------------------------
// Module   : exec_pkg
// Brief    : Shared constants and ALU op-code encodings for the execute stage.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package exec_pkg;

    localparam int XLEN = 32;

    typedef enum logic [5:0] {
        OP_ADD   = 6'h00,
        OP_SUB   = 6'h01,
        OP_AND   = 6'h02,
        OP_OR    = 6'h03,
        OP_XOR   = 6'h04,
        OP_SLL   = 6'h05,
        OP_SRL   = 6'h06,
        OP_SRA   = 6'h07,
        OP_SLT   = 6'h08,
        OP_SLTU  = 6'h09,
        OP_PASSB = 6'h0A,
        OP_AUIPC = 6'h0B,
        OP_BEQ   = 6'h10,
        OP_BNE   = 6'h11,
        OP_BLT   = 6'h12,
        OP_BGE   = 6'h13,
        OP_BLTU  = 6'h14,
        OP_BGEU  = 6'h15,
        OP_JAL   = 6'h18,
        OP_JALR  = 6'h19
    } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/exec_alu.sv
//------------------------------------------------------------------------------
// Module   : exec_alu
// Brief    : Combinational ALU plus branch/jump condition and target generation.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module exec_alu
    import exec_pkg::*;
(
    input  logic [5:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rdata1_i,
    output logic [XLEN-1:0] result_o,
    output logic            cond_o,
    output logic [XLEN-1:0] target_o
);

    localparam logic [XLEN-1:0] c_ALIGN_MASK = ~{{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] c_LINK_OFS   = XLEN'(4);

    logic [XLEN-1:0] w_br_tgt;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_link;
    logic [4:0]      w_shamt;
    logic            w_lt_s;
    logic            w_lt_u;

    assign w_br_tgt   = pc_i + imm_i;
    assign w_jalr_sum = rdata1_i + imm_i;
    assign w_link     = pc_i + c_LINK_OFS;
    assign w_shamt    = b_i[4:0];
    assign w_lt_s     = $signed(a_i) < $signed(b_i);
    assign w_lt_u     = a_i < b_i;

    always_comb begin
        result_o = '0;
        cond_o   = 1'b0;
        target_o = '0;
        case (op_i)
            OP_ADD:   result_o = a_i + b_i;
            OP_SUB:   result_o = a_i - b_i;
            OP_AND:   result_o = a_i & b_i;
            OP_OR:    result_o = a_i | b_i;
            OP_XOR:   result_o = a_i ^ b_i;
            OP_SLL:   result_o = a_i << w_shamt;
            OP_SRL:   result_o = a_i >> w_shamt;
            OP_SRA:   result_o = $unsigned($signed(a_i) >>> w_shamt);
            OP_SLT:   result_o = {{(XLEN-1){1'b0}}, w_lt_s};
            OP_SLTU:  result_o = {{(XLEN-1){1'b0}}, w_lt_u};
            OP_PASSB: result_o = b_i;
            OP_AUIPC: result_o = w_br_tgt;
            // Conditional branches produce no writeback value.
            OP_BEQ:   begin cond_o = (a_i == b_i); target_o = w_br_tgt; end
            OP_BNE:   begin cond_o = (a_i != b_i); target_o = w_br_tgt; end
            OP_BLT:   begin cond_o = w_lt_s;       target_o = w_br_tgt; end
            OP_BGE:   begin cond_o = ~w_lt_s;      target_o = w_br_tgt; end
            OP_BLTU:  begin cond_o = w_lt_u;       target_o = w_br_tgt; end
            OP_BGEU:  begin cond_o = ~w_lt_u;      target_o = w_br_tgt; end
            OP_JAL: begin
                result_o = w_link;
                cond_o   = 1'b1;
                target_o = w_br_tgt;
            end
            OP_JALR: begin
                result_o = w_link;
                cond_o   = 1'b1;
                target_o = w_jalr_sum & c_ALIGN_MASK;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/exec_top.sv
//------------------------------------------------------------------------------
// Module   : exec_top
// Brief    : Execute stage: ALU, branch resolution and registered results.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module exec_top
    import exec_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic [5:0]      ALU_Control,
    input  logic            branch_op,
    input  logic [XLEN-1:0] operand_A,
    input  logic [XLEN-1:0] operand_B,
    input  logic [XLEN-1:0] Rdata1,
    input  logic [XLEN-1:0] imm32,
    input  logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] ALU_result,
    output logic            jump_flag,
    output logic [XLEN-1:0] jump_target_PC
);

    logic [XLEN-1:0] result_d;
    logic [XLEN-1:0] target_d;
    logic            cond;
    logic            flag_d;

    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] target_q;
    logic            flag_q;

    exec_alu u_alu (
        .op_i     (ALU_Control),
        .a_i      (operand_A),
        .b_i      (operand_B),
        .pc_i     (PC),
        .imm_i    (imm32),
        .rdata1_i (Rdata1),
        .result_o (result_d),
        .cond_o   (cond),
        .target_o (target_d)
    );

    // The ALU only raises cond for branch/jump codes, so this gate suffices.
    assign flag_d = branch_op & cond;

    // rstn is active-high despite its name.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            result_q <= '0;
            flag_q   <= 1'b0;
            target_q <= '0;
        end else begin
            result_q <= result_d;
            flag_q   <= flag_d;
            target_q <= target_d;
        end
    end

    assign ALU_result     = result_q;
    assign jump_flag      = flag_q;
    assign jump_target_PC = target_q;

endmodule

`default_nettype wire

// File: tb/tb_exec_top.sv
//------------------------------------------------------------------------------
// Module   : tb_exec_top
// Brief    : Directed self-checking bench for exec_top.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_exec_top;

    logic        clk;
    logic        rstn;
    logic [5:0]  ALU_Control;
    logic        branch_op;
    logic [31:0] operand_A;
    logic [31:0] operand_B;
    logic [31:0] Rdata1;
    logic [31:0] imm32;
    logic [31:0] PC;
    logic [31:0] ALU_result;
    logic        jump_flag;
    logic [31:0] jump_target_PC;

    int n_tests;
    int n_fail;

    exec_top dut (
        .clk            (clk),
        .rstn           (rstn),
        .ALU_Control    (ALU_Control),
        .branch_op      (branch_op),
        .operand_A      (operand_A),
        .operand_B      (operand_B),
        .Rdata1         (Rdata1),
        .imm32          (imm32),
        .PC             (PC),
        .ALU_result     (ALU_result),
        .jump_flag      (jump_flag),
        .jump_target_PC (jump_target_PC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic bop, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r1,
                         input logic [31:0] imm, input logic [31:0] pc);
        @(negedge clk);
        ALU_Control = op;
        branch_op   = bop;
        operand_A   = a;
        operand_B   = b;
        Rdata1      = r1;
        imm32       = imm;
        PC          = pc;
    endtask

    // Apply one op, then check outputs 1 time unit after the capturing edge.
    task automatic run(input string tag, input logic [5:0] op, input logic bop,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] r1,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic [31:0] exp_res, input logic exp_flag,
                       input logic chk_tgt, input logic [31:0] exp_tgt);
        drive(op, bop, a, b, r1, imm, pc);
        @(posedge clk);
        #1;
        check({tag, ".res"}, ALU_result, exp_res);
        check({tag, ".flag"}, {31'b0, jump_flag}, {31'b0, exp_flag});
        if (chk_tgt) check({tag, ".tgt"}, jump_target_PC, exp_tgt);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn        = 1'b1;
        ALU_Control = 6'h18;
        branch_op   = 1'b1;
        operand_A   = 32'd1;
        operand_B   = 32'd2;
        Rdata1      = 32'h0;
        imm32       = 32'h10;
        PC          = 32'h40;

        // Outputs must stay 0 across edges while reset is held, even with a JAL driven.
        repeat (3) @(posedge clk);
        #1;
        check("rst.res",  ALU_result, 32'h0);
        check("rst.flag", {31'b0, jump_flag}, 32'h0);
        check("rst.tgt",  jump_target_PC, 32'h0);

        @(negedge clk);
        rstn = 1'b0;

        run("add",    6'h00, 1'b0, 32'd1,        32'd2,        0, 0, 0, 32'd3,        1'b0, 1'b0, 0);
        run("and",    6'h02, 1'b0, 32'd1,        32'd10,       0, 0, 0, 32'd0,        1'b0, 1'b0, 0);
        run("sra",    6'h07, 1'b0, 32'h80000000, 32'd4,        0, 0, 0, 32'hF8000000, 1'b0, 1'b0, 0);
        run("sub",    6'h01, 1'b0, 32'd0,        32'd1,        0, 0, 0, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
        run("slt",    6'h08, 1'b0, 32'hFFFFFFFF, 32'd1,        0, 0, 0, 32'd1,        1'b0, 1'b0, 0);
        run("sltu",   6'h09, 1'b0, 32'hFFFFFFFF, 32'd1,        0, 0, 0, 32'd0,        1'b0, 1'b0, 0);
        run("or",     6'h03, 1'b0, 32'hF0,       32'h0F,       0, 0, 0, 32'hFF,       1'b0, 1'b0, 0);
        run("xor",    6'h04, 1'b0, 32'hFF,       32'h0F,       0, 0, 0, 32'hF0,       1'b0, 1'b0, 0);
        run("sll",    6'h05, 1'b0, 32'd1,        32'h21,       0, 0, 0, 32'd2,        1'b0, 1'b0, 0);
        run("srl",    6'h06, 1'b0, 32'h80000000, 32'd31,       0, 0, 0, 32'd1,        1'b0, 1'b0, 0);
        run("passb",  6'h0A, 1'b0, 32'h5,        32'h12345000, 0, 0, 0, 32'h12345000, 1'b0, 1'b0, 0);
        run("auipc",  6'h0B, 1'b1, 32'h0,        32'h0,        0, 32'h20, 32'h1000, 32'h1020, 1'b0, 1'b0, 0);
        run("addwrap",6'h00, 1'b1, 32'hFFFFFFFF, 32'd1,        0, 0, 0, 32'd0,        1'b0, 1'b0, 0);

        run("beq_t",  6'h10, 1'b1, 32'd5, 32'd5, 0, 32'h20, 32'h100, 32'd0, 1'b1, 1'b1, 32'h120);
        run("beq_nb", 6'h10, 1'b0, 32'd5, 32'd5, 0, 32'h20, 32'h100, 32'd0, 1'b0, 1'b1, 32'h120);
        run("bne_nt", 6'h11, 1'b1, 32'd5, 32'd5, 0, 32'h20, 32'h100, 32'd0, 1'b0, 1'b1, 32'h120);
        run("blt",    6'h12, 1'b1, 32'hFFFFFFFF, 32'd1, 0, 32'h8, 32'h200, 32'd0, 1'b1, 1'b1, 32'h208);
        run("bltu",   6'h14, 1'b1, 32'hFFFFFFFF, 32'd1, 0, 32'h8, 32'h200, 32'd0, 1'b0, 1'b1, 32'h208);
        run("bge",    6'h13, 1'b1, 32'd1, 32'hFFFFFFFF, 0, 32'hFFFFFFF0, 32'h200, 32'd0, 1'b1, 1'b1, 32'h1F0);
        run("bge_eq", 6'h13, 1'b1, 32'd7, 32'd7, 0, 32'h4, 32'h10, 32'd0, 1'b1, 1'b1, 32'h14);
        run("bgeu",   6'h15, 1'b1, 32'd1, 32'hFFFFFFFF, 0, 32'h4, 32'h10, 32'd0, 1'b0, 1'b1, 32'h14);

        run("jalr",   6'h19, 1'b1, 0, 0, 32'h1001, 32'd4, 32'h40, 32'h44, 1'b1, 1'b1, 32'h1004);
        run("jal",    6'h18, 1'b1, 0, 0, 32'h0, 32'hFFFFFFF8, 32'h40, 32'h44, 1'b1, 1'b1, 32'h38);
        run("bad0c",  6'h0C, 1'b1, 32'd5, 32'd5, 32'h9, 32'h20, 32'h100, 32'd0, 1'b0, 1'b1, 32'h0);
        run("bad16",  6'h16, 1'b1, 32'd5, 32'd5, 32'h9, 32'h20, 32'h100, 32'd0, 1'b0, 1'b1, 32'h0);

        // Asynchronous reset between edges while a taken BEQ is registered.
        run("pre_ar", 6'h10, 1'b1, 32'd5, 32'd5, 0, 32'h20, 32'h100, 32'd0, 1'b1, 1'b1, 32'h120);
        #2;
        rstn = 1'b1;
        #1;
        check("async.flag", {31'b0, jump_flag}, 32'h0);
        check("async.tgt",  jump_target_PC, 32'h0);
        check("async.res",  ALU_result, 32'h0);
        @(negedge clk);
        rstn = 1'b0;
        run("post_ar", 6'h00, 1'b0, 32'd40, 32'd2, 0, 0, 0, 32'd42, 1'b0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
